// File: rtl/zone_position_tracker_if.sv
// rtl/zone_position_tracker_if.sv - pixel-in / zone-out bundle for zone_position_tracker
// oRoi_hit exists only when ZONE_TRACKER_ROI_EN is defined.
interface zone_position_tracker_if #(
    parameter int PIX_W  = 8,
    parameter int CNT_W  = 17,
    parameter int ZONE_W = 3
);
    logic [10:0]       iX;
    logic [10:0]       iY;
    logic [PIX_W-1:0]  iPix;
    logic              iValid;
    logic [ZONE_W-1:0] oZone;
    logic              oZone_valid;
    logic [CNT_W-1:0]  oWin_count;
    logic              oFrame_done;
    logic              oOverrun;
`ifdef ZONE_TRACKER_ROI_EN
    logic              oRoi_hit;
`endif

    modport master (
        output iX, iY, iPix, iValid,
        input  oZone, oZone_valid, oWin_count, oFrame_done, oOverrun
`ifdef ZONE_TRACKER_ROI_EN
        , input oRoi_hit
`endif
    );

    modport slave (
        input  iX, iY, iPix, iValid,
        output oZone, oZone_valid, oWin_count, oFrame_done, oOverrun
`ifdef ZONE_TRACKER_ROI_EN
        , output oRoi_hit
`endif
    );
endinterface

// File: rtl/zone_position_tracker.sv
// rtl/zone_position_tracker.sv - per-strip bright-pixel counter with debounced winning zone
// Optional row window and oRoi_hit enabled by ZONE_TRACKER_ROI_EN.
module zone_position_tracker #(
    parameter int               H_ACTIVE      = 640,
    parameter int               V_ACTIVE      = 480,
    parameter int               NUM_ZONES     = 8,
    parameter int               PIX_W         = 8,
    parameter logic [PIX_W-1:0] THRESH        = PIX_W'(200),
    parameter int               CNT_W         = 17,
    parameter int               MIN_COUNT     = 64,
    parameter int               STABLE_FRAMES = 3,
`ifdef ZONE_TRACKER_ROI_EN
    parameter int               ROI_Y0        = 0,
    parameter int               ROI_Y1        = V_ACTIVE - 1,
`endif
    parameter int               ZONE_W        = $clog2(NUM_ZONES)
) (
    input  logic                     CLOCK_50,
    input  logic                     resetn,
    zone_position_tracker_if.slave   bus
);
    localparam int               ZONE_PIX = H_ACTIVE / NUM_ZONES;
    localparam int               STAB_W   = $clog2(STABLE_FRAMES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    typedef enum logic [1:0] {IDLE, ACCUM, EVAL, DECIDE} state_t;

    state_t            r_state;
    state_t            w_state_next;

    logic [CNT_W-1:0]  r_live   [NUM_ZONES];
    logic [CNT_W-1:0]  r_shadow [NUM_ZONES];
    logic [ZONE_W-1:0] r_scan;
    logic [ZONE_W-1:0] r_max_idx;
    logic [CNT_W-1:0]  r_max;
    logic [ZONE_W-1:0] r_cand;
    logic [STAB_W-1:0] r_stab;
    logic [STAB_W-1:0] r_absent;
    logic [ZONE_W-1:0] r_zone;
    logic              r_zone_valid;
    logic [CNT_W-1:0]  r_win_count;
    logic              r_frame_done;
    logic              r_overrun;

    logic [ZONE_W-1:0] w_zone;
    logic              w_in_frame;
    logic              w_hit;
    logic              w_boundary;
    logic              w_snapshot;
    logic              w_restart;
    logic              w_present;
    logic [ZONE_W-1:0] w_cand_next;
    logic [STAB_W-1:0] w_stab_next;
    logic [STAB_W-1:0] w_absent_next;

    // Constant-threshold compare chain instead of a divider.
    always_comb begin
        w_zone = '0;
        for (int z = 1; z < NUM_ZONES; z++) begin
            if (int'(bus.iX) >= z * ZONE_PIX)
                w_zone = ZONE_W'(z);
        end
    end

    always_comb begin
        w_in_frame = (int'(bus.iX) < H_ACTIVE) && (int'(bus.iY) < V_ACTIVE);
`ifdef ZONE_TRACKER_ROI_EN
        w_in_frame = w_in_frame && (int'(bus.iY) >= ROI_Y0) && (int'(bus.iY) <= ROI_Y1);
`endif
        w_hit      = bus.iValid && w_in_frame && (bus.iPix > THRESH);
        w_boundary = bus.iValid && (bus.iX == 11'd0) && (bus.iY == 11'd0);
        w_snapshot = w_boundary && (r_state == ACCUM);
        w_restart  = w_boundary && ((r_state == ACCUM) || (r_state == IDLE));
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (w_boundary) w_state_next = ACCUM;
            ACCUM:   if (w_boundary) w_state_next = EVAL;
            EVAL:    if (r_scan == ZONE_W'(NUM_ZONES - 1)) w_state_next = DECIDE;
            DECIDE:  w_state_next = ACCUM;
            default: w_state_next = IDLE;
        endcase
    end

    always_comb begin
        w_present     = int'(r_max) >= MIN_COUNT;
        w_cand_next   = r_cand;
        w_stab_next   = r_stab;
        w_absent_next = r_absent;
        if (w_present) begin
            w_absent_next = '0;
            if (r_max_idx == r_cand) begin
                if (r_stab != STAB_W'(STABLE_FRAMES))
                    w_stab_next = r_stab + 1'b1;
            end else begin
                w_cand_next = r_max_idx;
                w_stab_next = STAB_W'(1);
            end
        end else begin
            w_stab_next = '0;
            if (r_absent != STAB_W'(STABLE_FRAMES))
                w_absent_next = r_absent + 1'b1;
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (!resetn)
            r_state <= IDLE;
        else
            r_state <= w_state_next;
    end

    always_ff @(posedge CLOCK_50) begin
        if (!resetn) begin
            for (int z = 0; z < NUM_ZONES; z++) begin
                r_live[z]   <= '0;
                r_shadow[z] <= '0;
            end
            r_scan       <= '0;
            r_max_idx    <= '0;
            r_max        <= '0;
            r_cand       <= '0;
            r_stab       <= '0;
            r_absent     <= '0;
            r_zone       <= '0;
            r_zone_valid <= 1'b0;
            r_win_count  <= '0;
            r_frame_done <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            // The boundary pixel itself opens the new frame, so it lands in the cleared bank.
            for (int z = 0; z < NUM_ZONES; z++) begin
                if (w_restart)
                    r_live[z] <= (w_hit && (w_zone == ZONE_W'(z))) ? CNT_W'(1) : '0;
                else if (w_hit && (w_zone == ZONE_W'(z)) && (r_live[z] != CNT_MAX))
                    r_live[z] <= r_live[z] + 1'b1;
                if (w_snapshot)
                    r_shadow[z] <= r_live[z];
            end

            r_frame_done <= 1'b0;
            r_overrun    <= w_boundary && ((r_state == EVAL) || (r_state == DECIDE));

            case (r_state)
                ACCUM: begin
                    if (w_snapshot) begin
                        r_scan    <= '0;
                        r_max     <= '0;
                        r_max_idx <= '0;
                    end
                end
                EVAL: begin
                    // Strict compare keeps the lowest index on ties.
                    if (r_shadow[r_scan] > r_max) begin
                        r_max     <= r_shadow[r_scan];
                        r_max_idx <= r_scan;
                    end
                    r_scan <= r_scan + 1'b1;
                end
                DECIDE: begin
                    r_cand       <= w_cand_next;
                    r_stab       <= w_stab_next;
                    r_absent     <= w_absent_next;
                    r_win_count  <= r_max;
                    r_frame_done <= 1'b1;
                    if (w_present && (w_stab_next == STAB_W'(STABLE_FRAMES))) begin
                        r_zone       <= w_cand_next;
                        r_zone_valid <= 1'b1;
                    end else if (!w_present && (w_absent_next == STAB_W'(STABLE_FRAMES))) begin
                        r_zone_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef ZONE_TRACKER_ROI_EN
    logic r_roi_hit;

    always_ff @(posedge CLOCK_50) begin
        if (!resetn)
            r_roi_hit <= 1'b0;
        else if (w_restart)
            r_roi_hit <= w_hit;
        else if (w_hit)
            r_roi_hit <= 1'b1;
    end

    assign bus.oRoi_hit = r_roi_hit;
`endif

    assign bus.oZone       = r_zone;
    assign bus.oZone_valid = r_zone_valid;
    assign bus.oWin_count  = r_win_count;
    assign bus.oFrame_done = r_frame_done;
    assign bus.oOverrun    = r_overrun;
endmodule

// File: tb/tb_zone_position_tracker.sv
// tb/tb_zone_position_tracker.sv - randomized frames against a per-frame count model
module tb_zone_position_tracker;
    localparam int NZ    = 8;
    localparam int ZPIX  = 80;
    localparam int MINC  = 64;
    localparam int STABF = 3;
    localparam int SATV  = 131071;

    logic CLOCK_50 = 1'b0;
    logic resetn   = 1'b0;
    always #5 CLOCK_50 = ~CLOCK_50;

    zone_position_tracker_if #(.PIX_W(8), .CNT_W(17), .ZONE_W(3)) bus ();
    zone_position_tracker_if #(.PIX_W(8), .CNT_W(4),  .ZONE_W(3)) sbus ();

    assign sbus.iX     = bus.iX;
    assign sbus.iY     = bus.iY;
    assign sbus.iPix   = bus.iPix;
    assign sbus.iValid = bus.iValid;

    zone_position_tracker dut (
        .CLOCK_50 (CLOCK_50),
        .resetn   (resetn),
        .bus      (bus)
    );

    zone_position_tracker #(.CNT_W(4)) dut_sat (
        .CLOCK_50 (CLOCK_50),
        .resetn   (resetn),
        .bus      (sbus)
    );

    int errors = 0;
    int checks = 0;

    int cur [NZ];
    int plan [NZ];
    int m_cand, m_stab, m_absent, m_zone, m_valid, m_win;
    bit started;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int z = 0; z < NZ; z++) cur[z] = 0;
        m_cand = 0; m_stab = 0; m_absent = 0;
        m_zone = 0; m_valid = 0; m_win = 0;
        started = 0;
    endtask

    task automatic model_pixel(input int x, input int y, input int p, input int v);
        if (v != 0 && x < 640 && y < 480 && p > 200 && cur[x / ZPIX] < SATV)
            cur[x / ZPIX]++;
    endtask

    task automatic model_eval();
        int mx = 0;
        int mi = 0;
        for (int z = 0; z < NZ; z++)
            if (cur[z] > mx) begin mx = cur[z]; mi = z; end
        if (mx >= MINC) begin
            m_absent = 0;
            if (mi == m_cand) m_stab = (m_stab < STABF) ? m_stab + 1 : STABF;
            else begin m_cand = mi; m_stab = 1; end
            if (m_stab == STABF) begin m_zone = m_cand; m_valid = 1; end
        end else begin
            m_stab = 0;
            m_absent = (m_absent < STABF) ? m_absent + 1 : STABF;
            if (m_absent == STABF) m_valid = 0;
        end
        m_win = mx;
        for (int z = 0; z < NZ; z++) cur[z] = 0;
    endtask

    task automatic pix(input int x, input int y, input int p, input int v);
        bus.iX = 11'(x); bus.iY = 11'(y); bus.iPix = 8'(p); bus.iValid = v[0];
        @(posedge CLOCK_50);
        #1;
        model_pixel(x, y, p, v);
    endtask

    task automatic idle(input int n);
        bus.iValid = 1'b0;
        for (int i = 0; i < n; i++) begin @(posedge CLOCK_50); #1; end
    endtask

    task automatic wait_done(input int used);
        int lat = 0;
        bus.iValid = 1'b0;
        for (int c = used + 1; c <= used + 30; c++) begin
            @(posedge CLOCK_50); #1;
            if (bus.oFrame_done === 1'b1) begin lat = c; break; end
        end
        chk("done_latency", lat, NZ + 1);
        chk("zone", 32'(bus.oZone), m_zone);
        chk("zone_valid", 32'(bus.oZone_valid), m_valid);
        chk("win_count", 32'(bus.oWin_count), m_win);
        @(posedge CLOCK_50); #1;
        chk("done_pulse_width", 32'(bus.oFrame_done), 0);
    endtask

    task automatic frame_end();
        bit was = started;
        int seen = 0;
        if (started) model_eval();
        for (int z = 0; z < NZ; z++) cur[z] = 0;
        started = 1;
        pix(0, 0, $urandom_range(0, 255), 1);
        if (was) wait_done(0);
        else begin
            bus.iValid = 1'b0;
            for (int i = 0; i < 14; i++) begin
                @(posedge CLOCK_50); #1;
                if (bus.oFrame_done === 1'b1) seen++;
            end
            chk("no_done_first_boundary", seen, 0);
        end
    endtask

    task automatic noise();
        int k = $urandom_range(0, 3);
        case (k)
            0: pix($urandom_range(1, 639), $urandom_range(0, 479), $urandom_range(0, 200), 1);
            1: pix($urandom_range(640, 2047), $urandom_range(0, 479), 255, 1);
            2: pix($urandom_range(0, 2047), $urandom_range(480, 2047), 255, 1);
            default: pix(0, 0, 255, 0);
        endcase
    endtask

    task automatic frame_body();
        int x, y;
        for (int z = 0; z < NZ; z++) begin
            for (int h = 0; h < plan[z]; h++) begin
                x = z * ZPIX + $urandom_range(0, ZPIX - 1);
                y = $urandom_range(0, 479);
                if (x == 0 && y == 0) y = 1;
                pix(x, y, $urandom_range(201, 255), 1);
                if ($urandom_range(0, 3) == 0) noise();
            end
        end
        bus.iValid = 1'b0;
    endtask

    task automatic set_plan(input int za, input int na, input int zb, input int nb);
        for (int z = 0; z < NZ; z++) plan[z] = 0;
        if (za >= 0) plan[za] = na;
        if (zb >= 0) plan[zb] = nb;
    endtask

    task automatic run_frame();
        frame_body();
        frame_end();
    endtask

    task automatic check_outputs_zero(input string tag);
        chk({tag, "_zone"}, 32'(bus.oZone), 0);
        chk({tag, "_valid"}, 32'(bus.oZone_valid), 0);
        chk({tag, "_win"}, 32'(bus.oWin_count), 0);
        chk({tag, "_done"}, 32'(bus.oFrame_done), 0);
        chk({tag, "_overrun"}, 32'(bus.oOverrun), 0);
    endtask

    initial begin
        int seen;
        bus.iX = '0; bus.iY = '0; bus.iPix = '0; bus.iValid = 1'b0;
        model_reset();

        resetn = 1'b0;
        repeat (2) @(posedge CLOCK_50);
        #1;
        check_outputs_zero("reset");
        resetn = 1'b1;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge CLOCK_50); #1;
            if (bus.oFrame_done === 1'b1) seen++;
        end
        chk("no_done_without_pixels", seen, 0);
        check_outputs_zero("idle");

        frame_end();

        set_plan(2, 300, -1, 0);
        repeat (3) run_frame();
        chk("zone2_commit", 32'(bus.oZone), 2);
        chk("zone2_valid", 32'(bus.oZone_valid), 1);

        set_plan(3, 100, 5, 100);
        repeat (3) run_frame();
        chk("tie_lowest_index", 32'(bus.oZone), 3);

        set_plan(-1, 0, -1, 0);
        repeat (3) run_frame();
        chk("absent_clears_valid", 32'(bus.oZone_valid), 0);

        for (int f = 0; f < 4; f++) begin
            set_plan((f % 2 == 0) ? 1 : 4, 100, -1, 0);
            run_frame();
        end
        chk("alternating_invalid", 32'(bus.oZone_valid), 0);

        set_plan(6, 50, -1, 0);
        repeat (3) run_frame();
        chk("below_min_invalid", 32'(bus.oZone_valid), 0);

        set_plan(6, 100, -1, 0);
        repeat (3) run_frame();
        chk("zone6_commit", 32'(bus.oZone), 6);
        chk("zone6_valid", 32'(bus.oZone_valid), 1);

        for (int f = 0; f < 6; f++) begin
            for (int z = 0; z < NZ; z++) plan[z] = $urandom_range(0, 120);
            run_frame();
        end

        set_plan(7, 80, -1, 0);
        frame_body();
        model_eval();
        pix(0, 0, $urandom_range(0, 255), 1);
        for (int i = 0; i < 3; i++) pix(600, 10, 255, 1);
        pix(0, 0, 255, 1);
        chk("overrun_pulse", 32'(bus.oOverrun), 1);
        wait_done(4);
        chk("overrun_pulse_width", 32'(bus.oOverrun), 0);
        set_plan(7, 70, -1, 0);
        run_frame();

        set_plan(1, 20, -1, 0);
        run_frame();
        chk("saturated_win_count", 32'(sbus.oWin_count), 15);

        pix(0, 0, 255, 1);
        idle(3);
        resetn = 1'b0;
        @(posedge CLOCK_50); #1;
        check_outputs_zero("mid_eval_reset");
        resetn = 1'b1;
        model_reset();
        seen = 0;
        for (int i = 0; i < 15; i++) begin
            @(posedge CLOCK_50); #1;
            if (bus.oFrame_done === 1'b1) seen++;
        end
        chk("no_done_after_reset", seen, 0);
        frame_end();
        set_plan(5, 100, -1, 0);
        run_frame();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
